// File: rtl/col_scanner.sv
// col_scanner: time-multiplexed column driver for a scanned LED/key matrix.
// Each column is preceded by a blanking gap, whose first cycle requests row data.
module col_scanner #(
    parameter int NCOLS       = 8,
    parameter int DWELL_W     = 8,
    parameter int ACTIVE_HIGH = 1,
    localparam int CW         = (NCOLS > 1) ? $clog2(NCOLS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         blank,
    output logic [NCOLS-1:0]   col_drive,
    output logic [CW-1:0]      col_idx,
    output logic               col_start,
    output logic               frame_start
);

    localparam int               CNT_W      = (DWELL_W > 4) ? DWELL_W : 4;
    localparam logic [CW-1:0]    LAST_IDX   = CW'(NCOLS - 1);
    localparam logic [NCOLS-1:0] IDLE_LEVEL = (ACTIVE_HIGH != 0) ? '0 : '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [NCOLS-1:0] drive_q, drive_d;
    logic             start_q, start_d;
    logic             frame_q, frame_d;
    logic [NCOLS-1:0] onehot;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            drive_q <= IDLE_LEVEL;
            start_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            drive_q <= drive_d;
            start_q <= start_d;
            frame_q <= frame_d;
        end
    end

    // The counter is only reloaded on phase entry, so dwell/blank changes apply at the next phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    cnt_d   = CNT_W'(blank);
                    idx_d   = '0;
                end
                S_BLANK: begin
                    if (cnt_zero) begin
                        state_d = S_ON;
                        cnt_d   = CNT_W'(dwell);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_ON: begin
                    if (cnt_zero) begin
                        state_d = S_BLANK;
                        cnt_d   = CNT_W'(blank);
                        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + CW'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NCOLS; gi++) begin : g_sel
            assign onehot[gi] = (idx_d == CW'(gi));
        end
    endgenerate

    // Outputs are computed from the next state so the registered copies line up with it.
    always_comb begin
        drive_d = IDLE_LEVEL;
        start_d = 1'b0;
        frame_d = 1'b0;
        if (state_d == S_ON) begin
            drive_d = (ACTIVE_HIGH != 0) ? onehot : ~onehot;
        end
        if ((state_d == S_BLANK) && (state_q != S_BLANK)) begin
            start_d = 1'b1;
            frame_d = (idx_d == '0);
        end
    end

    assign col_drive   = drive_q;
    assign col_idx     = idx_q;
    assign col_start   = start_q;
    assign frame_start = frame_q;

endmodule
